chess_clock_multi: RTL and testbench

- Parametrised N-player successor of the single-channel BCD mm:ss countdown used in the chess timer.
- Holds one BCD minutes/seconds register pair per player and decrements only the active player's pair from an internal prescaled one-second tick.
- Adds Fischer increment on turn switch, flags expiry per player without auto-reload, and supports pause/resume.
- Sits between the button debouncers/FSM and the 7-segment display mux.

---
 rtl/chess_clock_pkg.sv | 34 +++
 rtl/bcd_mmss_alu.sv | 67 ++++++
 rtl/chess_clock_multi.sv | 130 +++++++++++++
 tb/tb_chess_clock_multi.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the multi-player BCD chess clock.
package chess_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FLAG  = 2'd3
    } state_t;

    typedef enum logic {
        OP_DEC1    = 1'b0,
        OP_ADD_INC = 1'b1
    } alu_op_t;

    // Decoded command after priority resolution (load > pause > start > switch).
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_PAUSE,
        CMD_START,
        CMD_SWITCH
    } cmd_t;

    localparam logic [7:0] BCD_59   = 8'h59;
    localparam logic [7:0] BCD_99   = 8'h99;
    localparam logic [7:0] BCD_ZERO = 8'h00;

    // LSB position of channel idx inside a flattened 8-bit-per-channel bus.
    function automatic int unsigned ch_lsb(input int unsigned idx);
        return idx * 32'd8;
    endfunction

endpackage

// File: rtl/bcd_mmss_alu.sv
// Combinational BCD mm:ss arithmetic: one-second decrement or Fischer
// increment add with carry into minutes and 99:59 saturation.
module bcd_mmss_alu
    import chess_clock_pkg::*;
(
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [7:0] inc,
    input  alu_op_t    op,
    output logic [7:0] next_min,
    output logic [7:0] next_sec,
    output logic       zero
);

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Decrement a two-digit BCD byte, borrowing from the tens digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] b);
        if (b[3:0] == 4'd0) begin
            return {b[7:4] - 4'd1, 4'h9};
        end
        return {b[7:4], b[3:0] - 4'd1};
    endfunction

    logic [6:0] sec_sum;
    logic [6:0] min_sum;

    // Next mm:ss value for the selected operation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        next_min = min;
        next_sec = sec;
        sec_sum  = '0;
        min_sum  = '0;
        if (op == OP_DEC1) begin
            if (sec != BCD_ZERO) begin
                next_sec = bcd_dec(sec);
            end else if (min != BCD_ZERO) begin
                next_sec = BCD_59;
                next_min = bcd_dec(min);
            end
        end else begin
            sec_sum = bcd2bin(sec) + bcd2bin(inc);
            min_sum = bcd2bin(min);
            if (sec_sum >= 7'd60) begin
                sec_sum = sec_sum - 7'd60;
                min_sum = min_sum + 7'd1;
            end
            if (min_sum > 7'd99) begin
                next_min = BCD_99;
                next_sec = BCD_59;
            end else begin
                next_min = bin2bcd(min_sum);
                next_sec = bin2bcd(sec_sum);
            end
        end
    end

    assign zero = (next_min == BCD_ZERO) && (next_sec == BCD_ZERO);

endmodule

// File: rtl/chess_clock_multi.sv
// N-player BCD mm:ss chess clock with prescaled one-second tick, Fischer
// increment on turn switch, sticky per-player expiry flags and pause/resume.
module chess_clock_multi
    import chess_clock_pkg::*;
#(
    parameter int PLAYERS  = 2,
    parameter int TICK_DIV = 100,
    parameter int AW       = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [7:0]             time_min,
    input  logic [7:0]             inc_sec,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   switch,
    output logic [AW-1:0]          active,
    output logic [8*PLAYERS-1:0]   min_flat,
    output logic [8*PLAYERS-1:0]   sec_flat,
    output logic [PLAYERS-1:0]     flag,
    output logic                   running
);

    localparam int PW = $clog2(TICK_DIV);

    state_t                    state;
    cmd_t                      cmd;
    logic [PW-1:0]             presc;
    logic [PLAYERS-1:0][7:0]   min_q;
    logic [PLAYERS-1:0][7:0]   sec_q;

    logic                      tick;
    logic                      active_zero;
    logic [AW-1:0]             next_active;
    alu_op_t                   alu_op;
    logic [7:0]                alu_min;
    logic [7:0]                alu_sec;
    logic                      alu_zero;

    // Resolve simultaneous command pulses to the single highest-priority one.
    always_comb begin
        cmd = CMD_NONE;
        if (load) begin
            cmd = CMD_LOAD;
        end else if (pause) begin
            cmd = CMD_PAUSE;
        end else if (start) begin
            cmd = CMD_START;
        end else if (switch) begin
            cmd = CMD_SWITCH;
        end
    end

    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign active_zero = (min_q[active] == BCD_ZERO) && (sec_q[active] == BCD_ZERO);
    assign next_active = (active == AW'(PLAYERS - 1)) ? '0 : active + 1'b1;
    assign alu_op      = (state == ST_RUN && cmd == CMD_SWITCH) ? OP_ADD_INC : OP_DEC1;

    bcd_mmss_alu u_alu (
        .min      (min_q[active]),
        .sec      (sec_q[active]),
        .inc      (inc_sec),
        .op       (alu_op),
        .next_min (alu_min),
        .next_sec (alu_sec),
        .zero     (alu_zero)
    );

    for (genvar i = 0; i < PLAYERS; i++) begin : g_flat
        assign min_flat[ch_lsb(i) +: 8] = min_q[i];
        assign sec_flat[ch_lsb(i) +: 8] = sec_q[i];
    end

    // Control FSM, prescaler and per-channel time registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the channel registers are few and drive outputs directly, so they are reset like any other flop.
            state   <= ST_IDLE;
            presc   <= '0;
            active  <= '0;
            flag    <= '0;
            running <= 1'b0;
            min_q   <= '0;
            sec_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_RUN: begin
                    if (cmd == CMD_PAUSE) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (cmd == CMD_SWITCH) begin
                        // Switch wins over a coincident tick; the decrement is discarded.
                        min_q[active] <= alu_min;
                        sec_q[active] <= alu_sec;
                        active        <= next_active;
                        presc         <= '0;
                    end else if (tick) begin
                        presc         <= '0;
                        min_q[active] <= alu_min;
                        sec_q[active] <= alu_sec;
                        if (alu_zero) begin
                            flag[active] <= 1'b1;
                            state        <= ST_FLAG;
                            running      <= 1'b0;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: begin
                    if (cmd == CMD_LOAD) begin
                        min_q   <= {PLAYERS{time_min}};
                        sec_q   <= {PLAYERS{BCD_ZERO}};
                        flag    <= '0;
                        active  <= '0;
                        presc   <= '0;
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end else if (cmd == CMD_START && state != ST_FLAG && !active_zero) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chess_clock_multi.sv
// Self-checking bench for chess_clock_multi: a seconds-based reference model
// compared on every falling edge, plus directed literal expectations.
module tb_chess_clock_multi;

    localparam int PLAYERS  = 2;
    localparam int TICK_DIV = 4;
    localparam int MAX_S    = 99 * 60 + 59;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_FLAG   = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 load = 1'b0;
    logic                 start = 1'b0;
    logic                 pause = 1'b0;
    logic                 switch = 1'b0;
    logic [7:0]           time_min = 8'h00;
    logic [7:0]           inc_sec = 8'h00;
    logic [0:0]           active;
    logic [8*PLAYERS-1:0] min_flat;
    logic [8*PLAYERS-1:0] sec_flat;
    logic [PLAYERS-1:0]   flag;
    logic                 running;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model: remaining time per player in plain seconds.
    int rem [PLAYERS];
    bit flg [PLAYERS];
    int act;
    int mode;
    int phase;

    chess_clock_multi #(
        .PLAYERS  (PLAYERS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .time_min (time_min),
        .inc_sec  (inc_sec),
        .start    (start),
        .pause    (pause),
        .switch   (switch),
        .active   (active),
        .min_flat (min_flat),
        .sec_flat (sec_flat),
        .flag     (flag),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int bcd_to_int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int_to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [7:0] dmin(input int p);
        return min_flat[8*p +: 8];
    endfunction

    function automatic logic [7:0] dsec(input int p);
        return sec_flat[8*p +: 8];
    endfunction

    task automatic model_reset();
        for (int p = 0; p < PLAYERS; p++) begin
            rem[p] = 0;
            flg[p] = 1'b0;
        end
        act   = 0;
        mode  = M_IDLE;
        phase = 0;
    endtask

    // One rising edge of the model, using the inputs currently applied.
    task automatic model_edge();
        bit was_run;
        bit consumed;
        was_run  = (mode == M_RUN);
        consumed = 1'b0;
        if (load) begin
            if (mode != M_RUN) begin
                for (int p = 0; p < PLAYERS; p++) begin
                    rem[p] = bcd_to_int(time_min) * 60;
                    flg[p] = 1'b0;
                end
                act   = 0;
                phase = 0;
                mode  = M_IDLE;
            end
        end else if (pause) begin
            if (mode == M_RUN) begin
                mode     = M_PAUSE;
                consumed = 1'b1;
            end
        end else if (start) begin
            if ((mode == M_IDLE || mode == M_PAUSE) && rem[act] != 0) mode = M_RUN;
        end else if (switch) begin
            if (mode == M_RUN) begin
                rem[act] = rem[act] + bcd_to_int(inc_sec);
                if (rem[act] > MAX_S) rem[act] = MAX_S;
                act      = (act + 1) % PLAYERS;
                phase    = 0;
                consumed = 1'b1;
            end
        end
        if (was_run && !consumed) begin
            phase++;
            if (phase == TICK_DIV) begin
                phase = 0;
                rem[act]--;
                if (rem[act] == 0) begin
                    flg[act] = 1'b1;
                    mode     = M_FLAG;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [PLAYERS-1:0] fexp;
        for (int p = 0; p < PLAYERS; p++) begin
            check($sformatf("ch%0d_min", p), 32'(dmin(p)), 32'(int_to_bcd(rem[p] / 60)));
            check($sformatf("ch%0d_sec", p), 32'(dsec(p)), 32'(int_to_bcd(rem[p] % 60)));
            fexp[p] = flg[p];
        end
        check("flag", 32'(flag), 32'(fexp));
        check("active", 32'(active), 32'(act));
        check("running", 32'(running), 32'(mode == M_RUN));
    endtask

    // Compare DUT against the model in the middle of every clock period.
    always @(negedge clk) begin
        if (cmp_en) compare_all();
    end

    task automatic step(input bit l, input bit s, input bit p, input bit w);
        load   = l;
        start  = s;
        pause  = p;
        switch = w;
        @(posedge clk);
        model_edge();
        #2;
        load   = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        switch = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b1;
        cmp_en = 1'b1;
        check("rst_active", 32'(active), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_flag", 32'(flag), 32'h0);
        check("rst_min_flat", 32'(min_flat), 32'h0);
        check("rst_sec_flat", 32'(sec_flat), 32'h0);

        // Load 01:00, start, first tick after four clocks.
        time_min = 8'h01;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("t1_pre_tick_sec", 32'(dsec(0)), 32'h00);
        idle(1);
        check("t1_ch0_min", 32'(dmin(0)), 32'h00);
        check("t1_ch0_sec", 32'(dsec(0)), 32'h59);
        check("t1_ch1_min", 32'(dmin(1)), 32'h01);
        check("t1_ch1_sec", 32'(dsec(1)), 32'h00);
        check("t1_running", 32'(running), 32'h1);

        // Asynchronous reset while running at 00:30.
        idle(116);
        check("t2_ch0_sec", 32'(dsec(0)), 32'h30);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("t2_min_flat", 32'(min_flat), 32'h0);
        check("t2_sec_flat", 32'(sec_flat), 32'h0);
        check("t2_flag", 32'(flag), 32'h0);
        check("t2_active", 32'(active), 32'h0);
        check("t2_running", 32'(running), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // 10:00 borrow, then pause mid-prescale and resume.
        time_min = 8'h10;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        check("t3_min", 32'(dmin(0)), 32'h09);
        check("t3_sec", 32'(dsec(0)), 32'h59);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("t3_paused_sec", 32'(dsec(0)), 32'h59);
        check("t3_paused_run", 32'(running), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("t3_resume_hold", 32'(dsec(0)), 32'h59);
        idle(1);
        check("t3_resume_tick", 32'(dsec(0)), 32'h58);

        // Fischer increment with carry into minutes, then player 1 runs.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        time_min = 8'h01;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(8);
        check("t4_pre_sec", 32'(dsec(0)), 32'h58);
        inc_sec = 8'h05;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_ch0_min", 32'(dmin(0)), 32'h01);
        check("t4_ch0_sec", 32'(dsec(0)), 32'h03);
        check("t4_active", 32'(active), 32'h1);
        idle(3);
        check("t4_ch1_hold", 32'(dsec(1)), 32'h00);
        idle(1);
        check("t4_ch1_min", 32'(dmin(1)), 32'h00);
        check("t4_ch1_sec", 32'(dsec(1)), 32'h59);

        // Expiry: flag sets, everything freezes, load clears it.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        time_min = 8'h01;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(236);
        check("t5_at_one_sec", 32'(dsec(0)), 32'h01);
        idle(3);
        check("t5_still_run", 32'(running), 32'h1);
        idle(1);
        check("t5_min", 32'(dmin(0)), 32'h00);
        check("t5_sec", 32'(dsec(0)), 32'h00);
        check("t5_flag", 32'(flag), 32'h1);
        check("t5_running", 32'(running), 32'h0);
        idle(5);
        check("t5_frozen_sec", 32'(dsec(0)), 32'h00);
        check("t5_frozen_ch1", 32'(dmin(1)), 32'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_start_ignored", 32'(running), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_switch_ignored", 32'(active), 32'h0);
        time_min = 8'h02;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_load_flag", 32'(flag), 32'h0);
        check("t5_load_min", 32'(dmin(0)), 32'h02);
        check("t5_load_run", 32'(running), 32'h0);

        // Saturation at 99:59.
        time_min = 8'h99;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        inc_sec = 8'h59;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_add59_min", 32'(dmin(0)), 32'h99);
        check("t6_add59_sec", 32'(dsec(0)), 32'h59);
        inc_sec = 8'h00;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_back_active", 32'(active), 32'h0);
        idle(4);
        check("t6_pre_sec", 32'(dsec(0)), 32'h58);
        inc_sec = 8'h05;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_sat_min", 32'(dmin(0)), 32'h99);
        check("t6_sat_sec", 32'(dsec(0)), 32'h59);
        check("t6_sat_active", 32'(active), 32'h1);

        // Switch on the tick edge at 00:01: no expiry, increment applied.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        time_min = 8'h01;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(236);
        check("t7_at_one_sec", 32'(dsec(0)), 32'h01);
        idle(3);
        inc_sec = 8'h05;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t7_min", 32'(dmin(0)), 32'h00);
        check("t7_sec", 32'(dsec(0)), 32'h06);
        check("t7_flag", 32'(flag), 32'h0);
        check("t7_active", 32'(active), 32'h1);
        check("t7_running", 32'(running), 32'h1);
        idle(4);
        check("t7_ch1_sec", 32'(dsec(1)), 32'h59);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
